// File: rtl/adder_arbiter.sv
// Two-requester arbiter sharing one 33-bit adder through an IDLE/ADD/DONE handshake.
// Define ADDER_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties); default is round-robin.
module adder_arbiter (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ0_VALID,
    input  logic [31:0] REQ0_A,
    input  logic [31:0] REQ0_B,
    output logic        REQ0_READY,
    input  logic        REQ1_VALID,
    input  logic [31:0] REQ1_A,
    input  logic [31:0] REQ1_B,
    output logic        REQ1_READY,
    output logic [31:0] RESULT,
    output logic        RESULT_CARRY,
    output logic        RESULT_ID,
    output logic        RESULT_VALID,
    input  logic        RESULT_ACK
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    logic [31:0] op_a_r;
    logic [31:0] op_b_r;
    logic        op_id_r;
    logic        can_grant_s;
    logic        grant_s;
    logic        grant_id_s;
    logic [32:0] sum_s;
`ifndef ADDER_ARB_FIXED_PRIO_EN
    logic        last_r;
`endif

    // The only adder in the block, fed from the latched operands.
    assign sum_s = {1'b0, op_a_r} + {1'b0, op_b_r};

    // Grant decision: when a grant may be issued and which port wins it.
    always_comb begin
        can_grant_s = 1'b0;
        grant_id_s  = 1'b0;
        if (RESET) begin
            can_grant_s = 1'b0;
        end else begin
            case (state_r)
                IDLE:    can_grant_s = 1'b1;
                DONE:    can_grant_s = RESULT_ACK;
                default: can_grant_s = 1'b0;
            endcase
        end
`ifdef ADDER_ARB_FIXED_PRIO_EN
        if (REQ0_VALID) begin
            grant_id_s = 1'b0;
        end else begin
            grant_id_s = REQ1_VALID;
        end
`else
        if (REQ0_VALID && REQ1_VALID) begin
            grant_id_s = ~last_r;
        end else begin
            grant_id_s = REQ1_VALID;
        end
`endif
        grant_s    = can_grant_s && (REQ0_VALID || REQ1_VALID);
        REQ0_READY = grant_s && !grant_id_s;
        REQ1_READY = grant_s && grant_id_s;
    end

    // Control FSM with operand capture and registered result outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r      <= IDLE;
            op_a_r       <= 32'd0;
            op_b_r       <= 32'd0;
            op_id_r      <= 1'b0;
            RESULT       <= 32'd0;
            RESULT_CARRY <= 1'b0;
            RESULT_ID    <= 1'b0;
            RESULT_VALID <= 1'b0;
`ifndef ADDER_ARB_FIXED_PRIO_EN
            last_r       <= 1'b1;
`endif
        end else begin
            // grant_s can only be high in IDLE or in DONE with ACK, so capture is shared.
            if (grant_s) begin
                op_a_r  <= grant_id_s ? REQ1_A : REQ0_A;
                op_b_r  <= grant_id_s ? REQ1_B : REQ0_B;
                op_id_r <= grant_id_s;
`ifndef ADDER_ARB_FIXED_PRIO_EN
                last_r  <= grant_id_s;
`endif
            end else begin
                op_id_r <= op_id_r;
            end
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        state_r <= ADD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ADD: begin
                    {RESULT_CARRY, RESULT} <= sum_s;
                    RESULT_ID              <= op_id_r;
                    RESULT_VALID           <= 1'b1;
                    state_r                <= DONE;
                end
                DONE: begin
                    if (RESULT_ACK) begin
                        RESULT_VALID <= 1'b0;
                        if (grant_s) begin
                            state_r <= ADD;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    RESULT_VALID <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: directed vectors push expected results, a monitor checks them.
module tb_adder_arbiter;

    logic        CLK;
    logic        RESET;
    logic        REQ0_VALID;
    logic [31:0] REQ0_A;
    logic [31:0] REQ0_B;
    logic        REQ0_READY;
    logic        REQ1_VALID;
    logic [31:0] REQ1_A;
    logic [31:0] REQ1_B;
    logic        REQ1_READY;
    logic [31:0] RESULT;
    logic        RESULT_CARRY;
    logic        RESULT_ID;
    logic        RESULT_VALID;
    logic        RESULT_ACK;

    typedef struct packed {
        logic        id;
        logic        carry;
        logic [31:0] sum;
    } exp_t;

    exp_t q[$];
    int   vectors;
    int   miscompares;

    adder_arbiter dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .REQ0_VALID   (REQ0_VALID),
        .REQ0_A       (REQ0_A),
        .REQ0_B       (REQ0_B),
        .REQ0_READY   (REQ0_READY),
        .REQ1_VALID   (REQ1_VALID),
        .REQ1_A       (REQ1_A),
        .REQ1_B       (REQ1_B),
        .REQ1_READY   (REQ1_READY),
        .RESULT       (RESULT),
        .RESULT_CARRY (RESULT_CARRY),
        .RESULT_ID    (RESULT_ID),
        .RESULT_VALID (RESULT_VALID),
        .RESULT_ACK   (RESULT_ACK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every accepted result is matched against the oldest expectation.
    always @(negedge CLK) begin
        exp_t e;
        if (RESET === 1'b0 && RESULT_VALID === 1'b1 && RESULT_ACK === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_result", {32'd0, RESULT_VALID}, 33'd0);
            end else begin
                e = q.pop_front();
                chk("result_sum",   {1'b0, RESULT},       {1'b0, e.sum});
                chk("result_carry", {32'd0, RESULT_CARRY}, {32'd0, e.carry});
                chk("result_id",    {32'd0, RESULT_ID},    {32'd0, e.id});
            end
        end
    end

    // One isolated add with ACK=1; operands are zeroed right after the grant.
    task automatic single_op(input logic port, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_sum, input logic exp_carry);
        if (port) begin
            REQ1_VALID = 1'b1; REQ1_A = a; REQ1_B = b;
        end else begin
            REQ0_VALID = 1'b1; REQ0_A = a; REQ0_B = b;
        end
        q.push_back({port, exp_carry, exp_sum});
        @(negedge CLK);
        chk("single_grant", {31'd0, REQ1_READY, REQ0_READY}, port ? 33'd2 : 33'd1);
        tick;
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        REQ0_A = 32'd0; REQ0_B = 32'd0; REQ1_A = 32'd0; REQ1_B = 32'd0;
        @(negedge CLK);
        chk("single_add_valid", {32'd0, RESULT_VALID}, 33'd0);
        chk("single_add_ready", {31'd0, REQ1_READY, REQ0_READY}, 33'd0);
        tick;
        @(negedge CLK);
        chk("single_latency_valid", {32'd0, RESULT_VALID}, 33'd1);
        tick;
    endtask

    initial begin
        logic exp_id;
        vectors = 0;
        miscompares = 0;
        RESET = 1'b1; RESULT_ACK = 1'b0;
        REQ0_VALID = 1'b0; REQ0_A = 32'd0; REQ0_B = 32'd0;
        REQ1_VALID = 1'b0; REQ1_A = 32'd0; REQ1_B = 32'd0;
        tick;
        REQ0_VALID = 1'b1;
        tick;
        @(negedge CLK);
        chk("reset_result",  {1'b0, RESULT}, 33'd0);
        chk("reset_valid",   {32'd0, RESULT_VALID}, 33'd0);
        chk("reset_carry",   {32'd0, RESULT_CARRY}, 33'd0);
        chk("reset_id",      {32'd0, RESULT_ID}, 33'd0);
        chk("reset_ready",   {31'd0, REQ1_READY, REQ0_READY}, 33'd0);
        tick;
        RESET = 1'b0; REQ0_VALID = 1'b0; RESULT_ACK = 1'b1;

        single_op(1'b0, 32'h0000_1000, 32'h0000_0024, 32'h0000_1024, 1'b0);
        single_op(1'b1, 32'hFFFF_FFFC, 32'h0000_0008, 32'h0000_0004, 1'b1);

        // Both requesters held valid; fresh reset leaves port 0 favoured first.
        RESET = 1'b1;
        tick;
        RESET = 1'b0;
        REQ0_VALID = 1'b1; REQ0_A = 32'd1;  REQ0_B = 32'd2;
        REQ1_VALID = 1'b1; REQ1_A = 32'd10; REQ1_B = 32'd20;
        for (int k = 0; k < 4; k++) begin
`ifdef ADDER_ARB_FIXED_PRIO_EN
            exp_id = 1'b0;
`else
            exp_id = (k % 2 == 1);
`endif
            q.push_back({exp_id, 1'b0, exp_id ? 32'd30 : 32'd3});
            @(negedge CLK);
            chk("both_grant", {31'd0, REQ1_READY, REQ0_READY}, exp_id ? 33'd2 : 33'd1);
            tick;
            if (k == 3) begin
                REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
            end
            @(negedge CLK);
            chk("both_add_ready", {31'd0, REQ1_READY, REQ0_READY}, 33'd0);
            tick;
        end
        @(negedge CLK);
        tick;

        // Result held while ACK is low, then back-to-back grant on ACK.
        RESULT_ACK = 1'b0;
        REQ0_VALID = 1'b1; REQ0_A = 32'd5; REQ0_B = 32'd7;
        q.push_back({1'b0, 1'b0, 32'd12});
        @(negedge CLK);
        chk("hold_grant0", {31'd0, REQ1_READY, REQ0_READY}, 33'd1);
        tick;
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b1; REQ1_A = 32'h100; REQ1_B = 32'h200;
        @(negedge CLK);
        chk("hold_add_ready", {31'd0, REQ1_READY, REQ0_READY}, 33'd0);
        tick;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("hold_valid",  {32'd0, RESULT_VALID}, 33'd1);
            chk("hold_result", {1'b0, RESULT}, 33'd12);
            chk("hold_ready",  {31'd0, REQ1_READY, REQ0_READY}, 33'd0);
            tick;
        end
        RESULT_ACK = 1'b1;
        q.push_back({1'b1, 1'b0, 32'h300});
        @(negedge CLK);
        chk("ack_grant1", {31'd0, REQ1_READY, REQ0_READY}, 33'd2);
        tick;
        REQ1_VALID = 1'b0; REQ1_A = 32'd0; REQ1_B = 32'd0;
        @(negedge CLK);
        chk("ack_add_valid", {32'd0, RESULT_VALID}, 33'd0);
        tick;
        @(negedge CLK);
        chk("ack_done_valid", {32'd0, RESULT_VALID}, 33'd1);
        tick;

        // Reset during ADD discards the operation.
        REQ0_VALID = 1'b1; REQ0_A = 32'd9; REQ0_B = 32'd9;
        @(negedge CLK);
        chk("abort_grant", {31'd0, REQ1_READY, REQ0_READY}, 33'd1);
        tick;
        REQ0_VALID = 1'b0; RESET = 1'b1;
        tick;
        RESET = 1'b0;
        @(negedge CLK);
        chk("abort_valid",  {32'd0, RESULT_VALID}, 33'd0);
        chk("abort_result", {1'b0, RESULT}, 33'd0);
        chk("abort_carry",  {32'd0, RESULT_CARRY}, 33'd0);
        chk("abort_id",     {32'd0, RESULT_ID}, 33'd0);
        for (int i = 0; i < 3; i++) begin
            tick;
            @(negedge CLK);
            chk("abort_stay_idle", {32'd0, RESULT_VALID}, 33'd0);
        end

        chk("queue_drained", q.size(), 33'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Port CLK  input  1  single clock; all state updates on rising edge.
REQ-002 Port RESET  input  1  synchronous, active-high reset, sampled on rising CLK edge.
REQ-003 Port REQ0_VALID  input  1  requester 0 (branch-target resolve) has an add pending.
REQ-004 Port REQ0_A, REQ0_B  input  32 each  requester 0 operands.
REQ-005 Port REQ0_READY  output  1  grant pulse; operands of requester 0 captured this edge.
REQ-006 Port REQ1_VALID  input  1  requester 1 (PC+4 / general) has an add pending.
REQ-007 Port REQ1_A, REQ1_B  input  32 each  requester 1 operands.
REQ-008 Port REQ1_READY  output  1  grant pulse for requester 1.
REQ-009 Port RESULT  output  32  sum of granted operands, modulo 2^32.
REQ-010 Port RESULT_CARRY  output  1  carry-out bit 32 of the sum.
REQ-011 Port RESULT_ID  output  1  requester that owns RESULT (0 or 1).
REQ-012 Port RESULT_VALID  output  1  RESULT/RESULT_CARRY/RESULT_ID valid and held.
REQ-013 Port RESULT_ACK  input  1  consumer accepts result; sampled only while RESULT_VALID=1.

Function
REQ-014 FSM states SHALL be IDLE, ADD, DONE; one shared 32-bit adder, no other adder instance.
REQ-015 IDLE: if any REQx_VALID, SHALL assert the winner's READY combinationally, latch its operands and ID at the edge, go to ADD; else stay IDLE.
REQ-016 ADD: SHALL register {carry,sum}=A+B (33-bit) into RESULT_CARRY/RESULT and go to DONE; exactly one cycle.
REQ-017 DONE: RESULT_VALID=1; all result outputs SHALL hold stable until RESULT_ACK=1.
REQ-018 DONE with RESULT_ACK=1 and a request pending: SHALL grant in the same cycle (READY high) and go to ADD (back-to-back issue, 2-cycle throughput).
REQ-019 DONE with RESULT_ACK=1 and no request: SHALL go to IDLE.
REQ-020 Latency: grant edge to RESULT_VALID=1 SHALL be 2 rising edges.
REQ-021 At most one READY SHALL be high in any cycle; READY never high in ADD or in DONE without RESULT_ACK.
REQ-022 Arbitration (default): round-robin; pointer LAST holds last granted ID; on simultaneous VALID the port != LAST wins; LAST updates on every grant.
REQ-023 Single requester valid: SHALL be granted regardless of LAST.
REQ-024 Operands SHALL be latched at grant; later changes on REQx_A/B SHALL not affect RESULT.
REQ-025 RESULT_ACK while RESULT_VALID=0 SHALL be ignored.
REQ-026 Overflow wraps: RESULT = (A+B) mod 2^32, RESULT_CARRY = 1 when A+B >= 2^32.

Reset
REQ-027 RESET=1 at an edge SHALL force state IDLE, RESULT=0, RESULT_CARRY=0, RESULT_ID=0, RESULT_VALID=0, LAST=1 (port 0 wins first tie).
REQ-028 READY outputs SHALL be 0 while RESET=1.
REQ-029 RESET in ADD or DONE SHALL discard the in-flight operation; no RESULT_VALID pulse for it.

Configuration
REQ-030 Macro ADDER_ARB_FIXED_PRIO_EN defined: fixed priority, port 0 always wins ties; LAST unused.
REQ-031 Macro undefined: round-robin per REQ-022; all other behaviour identical.

Verification
REQ-032 Reset then REQ0 only, A=0x00001000, B=0x00000024, ACK held 1 -> REQ0_READY cycle 0, RESULT=0x00001024, ID=0, CARRY=0, VALID at edge 2.
REQ-033 Both valid continuously, ACK=1 (round-robin build) -> grant order 0,1,0,1 every 2 cycles; fixed-prio build -> 0,0,0,0.
REQ-034 A=0xFFFFFFFC, B=0x00000008 -> RESULT=0x00000004, CARRY=1.
REQ-035 ACK held 0 for 5 cycles in DONE with REQ1 valid -> RESULT stable, no READY; ACK=1 -> REQ1_READY same cycle, next result 2 edges later.
REQ-036 RESET asserted during ADD -> next cycle IDLE, RESULT_VALID never asserts for that op, all outputs 0.
REQ-037 Operands changed to 0 the cycle after grant -> RESULT reflects originally latched values.
